// File: rtl/shift_chain_pkg.sv
// Shared types and default sizing for the shift-chain sequencer and its arbiter.
package shift_chain_pkg;

    localparam int DEFAULT_WIDTH       = 4;
    localparam int DEFAULT_HOLD_CYCLES = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    typedef logic req_id_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last time is granted.
module rr_arbiter2
    import shift_chain_pkg::*;
(
    input  logic    valid0,
    input  logic    valid1,
    input  req_id_t last_grant,
    output logic    grant0,
    output logic    grant1,
    output req_id_t winner,
    output req_id_t next_pointer
);

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (valid0 && valid1) begin
            grant0 = (last_grant == 1'b1);
            grant1 = (last_grant == 1'b0);
        end else begin
            grant0 = valid0;
            grant1 = valid1;
        end
        winner       = grant1;
        next_pointer = (grant0 || grant1) ? winner : last_grant;
    end

endmodule

// File: rtl/shift_chain_sequencer.sv
// Arbitrates two requesters and shifts the granted word MSB-first into the LED chain.
// Optional word parity output enabled by SHIFT_CHAIN_SEQ_PARITY_EN.
//
// state | meaning
// IDLE  | waiting for a request, readies follow the arbiter
// SHIFT | one chain bit per cycle for WIDTH cycles
// HOLD  | word displayed for HOLD_CYCLES, done on the last one
module shift_chain_sequencer
    import shift_chain_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
    input  logic             input_clock,
    input  logic             input_reset,
    input  logic             input_req0_valid,
    input  logic [WIDTH-1:0] input_req0_data,
    output logic             output_req0_ready,
    input  logic             input_req1_valid,
    input  logic [WIDTH-1:0] input_req1_data,
    output logic             output_req1_ready,
    output logic             output_busy,
    output logic             output_grant_id,
    output logic             output_shift_en,
    output logic             output_serial_bit,
    output logic [WIDTH-1:0] output_leds,
    output logic             output_done,
    output logic             output_parity
);

    localparam int CW = $clog2(max_int(WIDTH, HOLD_CYCLES) + 1);

    state_t           state, next_state;
    logic [WIDTH-1:0] leds, tx, aligned, accept_data;
    logic [CW-1:0]    counter;
    req_id_t          grant_id, pointer, winner, next_pointer;
    logic             grant0, grant1, accept;
    logic             shift_last, hold_last;

    rr_arbiter2 u_arbiter (
        .valid0       (input_req0_valid),
        .valid1       (input_req1_valid),
        .last_grant   (pointer),
        .grant0       (grant0),
        .grant1       (grant1),
        .winner       (winner),
        .next_pointer (next_pointer)
    );

    assign accept_data = winner ? input_req1_data : input_req0_data;
    assign shift_last  = (counter == CW'(WIDTH - 1));
    assign hold_last   = (counter == CW'(HOLD_CYCLES - 1));
    // MSB-first: bit WIDTH-1-counter moved down to position 0.
    assign aligned     = tx >> (CW'(WIDTH - 1) - counter);

    always_comb begin
        next_state        = state;
        accept            = 1'b0;
        output_req0_ready = 1'b0;
        output_req1_ready = 1'b0;
        output_busy       = 1'b0;
        output_shift_en   = 1'b0;
        output_serial_bit = 1'b0;
        output_done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!input_reset) begin
                    output_req0_ready = grant0;
                    output_req1_ready = grant1;
                    accept            = grant0 | grant1;
                end
                if (accept) next_state = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (!input_reset) begin
                    output_busy       = 1'b1;
                    output_shift_en   = 1'b1;
                    output_serial_bit = aligned[0];
                end
                if (shift_last) next_state = ST_HOLD;
            end
            ST_HOLD: begin
                output_busy = !input_reset;
                if (hold_last) begin
                    output_done = !input_reset;
                    next_state  = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge input_clock) begin
        if (input_reset) begin
            state    <= ST_IDLE;
            leds     <= '0;
            tx       <= '0;
            counter  <= '0;
            grant_id <= 1'b0;
            pointer  <= 1'b1;
        end else begin
            state <= next_state;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        tx       <= accept_data;
                        grant_id <= winner;
                        pointer  <= next_pointer;
                        counter  <= '0;
                    end
                end
                ST_SHIFT: begin
                    leds    <= {leds[WIDTH-2:0], output_serial_bit};
                    counter <= shift_last ? '0 : counter + CW'(1);
                end
                ST_HOLD: counter <= hold_last ? '0 : counter + CW'(1);
                default: counter <= '0;
            endcase
        end
    end

    assign output_leds     = leds;
    assign output_grant_id = grant_id;

`ifdef SHIFT_CHAIN_SEQ_PARITY_EN
    logic parity;

    always_ff @(posedge input_clock) begin
        if (input_reset) parity <= 1'b0;
        else if (accept) parity <= ^accept_data;
    end

    assign output_parity = parity;
`else
    assign output_parity = 1'b0;
`endif

endmodule

// File: tb/tb_shift_chain_sequencer.sv
// Self-checking bench: directed vector table, corner sequences and randomized traffic vs a transaction-level model.
module tb_shift_chain_sequencer;

    localparam int W = 4;
    localparam int H = 2;

    logic         clk = 1'b0;
    logic         input_reset = 1'b1;
    logic         input_req0_valid = 1'b0;
    logic [W-1:0] input_req0_data = '0;
    logic         input_req1_valid = 1'b0;
    logic [W-1:0] input_req1_data = '0;
    logic         output_req0_ready, output_req1_ready, output_busy, output_grant_id;
    logic         output_shift_en, output_serial_bit, output_done, output_parity;
    logic [W-1:0] output_leds;

    always #5 clk = ~clk;

    shift_chain_sequencer #(.WIDTH(W), .HOLD_CYCLES(H)) dut (
        .input_clock       (clk),
        .input_reset       (input_reset),
        .input_req0_valid  (input_req0_valid),
        .input_req0_data   (input_req0_data),
        .output_req0_ready (output_req0_ready),
        .input_req1_valid  (input_req1_valid),
        .input_req1_data   (input_req1_data),
        .output_req1_ready (output_req1_ready),
        .output_busy       (output_busy),
        .output_grant_id   (output_grant_id),
        .output_shift_en   (output_shift_en),
        .output_serial_bit (output_serial_bit),
        .output_leds       (output_leds),
        .output_done       (output_done),
        .output_parity     (output_parity)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit model_on = 0;

`ifdef SHIFT_CHAIN_SEQ_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    // Transaction model: ph = 0 idle, 1..W shifting, W+1..W+H holding.
    int ph, m_word, m_leds, m_gid, m_ptr, m_par;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic logic [11:0] obs();
        return {output_req0_ready, output_req1_ready, output_busy, output_grant_id,
                output_shift_en, output_serial_bit, output_leds, output_done, output_parity};
    endfunction

    task automatic model_step();
        int winner, e_r0, e_r1, e_busy, e_sh, e_ser, e_done, e_par, exp;
        winner = -1; e_r0 = 0; e_r1 = 0; e_busy = 0; e_sh = 0; e_ser = 0; e_done = 0;
        if (!input_reset) begin
            if (ph == 0) begin
                if (input_req0_valid && input_req1_valid) winner = (m_ptr == 0) ? 1 : 0;
                else if (input_req0_valid) winner = 0;
                else if (input_req1_valid) winner = 1;
                e_r0 = (winner == 0);
                e_r1 = (winner == 1);
            end else begin
                e_busy = 1;
                if (ph <= W) begin
                    e_sh  = 1;
                    e_ser = (m_word >> (W - ph)) & 1;
                end
                e_done = (ph == W + H);
            end
        end
        e_par = PAR_EN ? m_par : 0;
        exp = (e_r0 << 11) | (e_r1 << 10) | (e_busy << 9) | (m_gid << 8) | (e_sh << 7) |
              (e_ser << 6) | (m_leds << 2) | (e_done << 1) | e_par;
        chk($sformatf("model@%0d", cyc), int'(obs()), exp);
        if (input_reset) begin
            ph = 0; m_leds = 0; m_gid = 0; m_ptr = 1; m_par = 0; m_word = 0;
        end else if (ph == 0) begin
            if (winner >= 0) begin
                m_word = (winner == 1) ? int'(input_req1_data) : int'(input_req0_data);
                m_gid  = winner;
                m_ptr  = winner;
                m_par  = $countones(m_word) % 2;
                ph     = 1;
            end
        end else begin
            if (ph <= W) m_leds = ((m_leds << 1) | e_ser) & ((1 << W) - 1);
            ph = (ph == W + H) ? 0 : ph + 1;
        end
    endtask

    task automatic cycle(input logic rst, input logic v0, input logic [W-1:0] d0,
                         input logic v1, input logic [W-1:0] d1);
        @(negedge clk);
        input_reset      = rst;
        input_req0_valid = v0;
        input_req0_data  = d0;
        input_req1_valid = v1;
        input_req1_data  = d1;
        #1;
        if (model_on) model_step();
        else if (rst) begin
            ph = 0; m_leds = 0; m_gid = 0; m_ptr = 1; m_par = 0; m_word = 0;
            model_on = 1;
        end
        cyc++;
    endtask

    // Drive req0 until accepted, then idle until done; bounded.
    task automatic run_txn(input logic [W-1:0] d, output int acc_at, output int done_at);
        bit held;
        held = 1; acc_at = -1; done_at = -1;
        for (int k = 0; k < 20 && done_at < 0; k++) begin
            cycle(1'b0, held, d, 1'b0, '0);
            if (output_req0_ready && acc_at < 0) begin acc_at = k; held = 0; end
            if (output_done) done_at = k;
        end
    endtask

    typedef struct {
        logic         rst;
        logic         v0;
        logic [W-1:0] d0;
        logic         v1;
        logic [W-1:0] d1;
        logic [10:0]  exp;   // r0 r1 busy gid sh ser leds[3:0] done
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 11'b0_0_0_0_0_0_0000_0};
        tbl[1] = '{1'b0, 1'b1, 4'b1011, 1'b0, 4'b0000, 11'b1_0_0_0_0_0_0000_0};
        tbl[2] = '{1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 11'b0_0_1_0_1_1_0000_0};
        tbl[3] = '{1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 11'b0_0_1_0_1_0_0001_0};
        tbl[4] = '{1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 11'b0_0_1_0_1_1_0010_0};
        tbl[5] = '{1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 11'b0_0_1_0_1_1_0101_0};
        tbl[6] = '{1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 11'b0_0_1_0_0_0_1011_0};
        tbl[7] = '{1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 11'b0_0_1_0_0_0_1011_1};
        tbl[8] = '{1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 11'b0_0_0_0_0_0_1011_0};

        cycle(1'b1, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 9; i++) begin
            logic [11:0] g;
            cycle(tbl[i].rst, tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1);
            g = obs();
            chk($sformatf("vec%0d", i), int'(g[11:1]), int'(tbl[i].exp));
        end

        // Both requesters held valid right after reset: req0 first, req1 seven cycles later.
        begin
            int acc0, acc1, done_n;
            bit h0, h1;
            logic [W-1:0] led_done[2];
            int gid_done[2];
            acc0 = -1; acc1 = -1; done_n = 0; h0 = 1; h1 = 1;
            led_done[0] = '1; led_done[1] = '1; gid_done[0] = -1; gid_done[1] = -1;
            cycle(1'b1, 1'b0, '0, 1'b0, '0);
            for (int k = 0; k < 40 && done_n < 2; k++) begin
                cycle(1'b0, h0, 4'b0001, h1, 4'b1000);
                if (output_req0_ready && acc0 < 0) begin acc0 = k; h0 = 0; end
                if (output_req1_ready && acc1 < 0) begin acc1 = k; h1 = 0; end
                if (output_done) begin
                    led_done[done_n] = output_leds;
                    gid_done[done_n] = int'(output_grant_id);
                    done_n++;
                end
            end
            chk("tie_req0_first", acc0, 0);
            chk("tie_req1_gap", acc1 - acc0, 7);
            chk("tie_leds_first", int'(led_done[0]), 4'b0001);
            chk("tie_leds_second", int'(led_done[1]), 4'b1000);
            chk("tie_gid_first", gid_done[0], 0);
            chk("tie_gid_second", gid_done[1], 1);
        end

        // Reset during the second shift cycle aborts the transaction.
        begin
            int dones;
            dones = 0;
            cycle(1'b0, 1'b1, 4'b1011, 1'b0, '0);
            chk("abort_accept", int'(output_req0_ready), 1);
            cycle(1'b0, 1'b0, '0, 1'b0, '0);
            cycle(1'b1, 1'b0, '0, 1'b0, '0);
            chk("abort_busy_in_reset", int'({output_busy, output_shift_en, output_done}), 0);
            cycle(1'b0, 1'b0, '0, 1'b0, '0);
            chk("abort_leds", int'(output_leds), 0);
            chk("abort_busy", int'(output_busy), 0);
            for (int k = 0; k < 8; k++) begin
                cycle(1'b0, 1'b0, '0, 1'b0, '0);
                if (output_done) dones++;
            end
            chk("abort_no_done", dones, 0);
        end

        // Back-to-back req0 words: second accept in the cycle after done.
        begin
            int a1, d1, a2, d2;
            run_txn(4'b1111, a1, d1);
            run_txn(4'b0000, a2, d2);
            chk("b2b_first_done", d1 - a1, W + H);
            chk("b2b_second_accept", a2, 0);
            chk("b2b_second_done", d2 - a2, W + H);
            cycle(1'b0, 1'b0, '0, 1'b0, '0);
            chk("b2b_leds", int'(output_leds), 4'b0000);
        end

        // Parity of the accepted word.
        begin
            int a, d;
            cycle(1'b0, 1'b1, 4'b0111, 1'b0, '0);
            cycle(1'b0, 1'b0, '0, 1'b0, '0);
            chk("parity_0111", int'(output_parity), PAR_EN ? 1 : 0);
            run_txn(4'b0000, a, d);
            cycle(1'b0, 1'b1, 4'b0110, 1'b0, '0);
            cycle(1'b0, 1'b0, '0, 1'b0, '0);
            chk("parity_0110", int'(output_parity), 0);
            run_txn(4'b0000, a, d);
        end

        // Randomized traffic, including occasional resets.
        for (int k = 0; k < 600; k++) begin
            cycle(($urandom_range(0, 49) == 0),
                  1'($urandom_range(0, 1)), W'($urandom),
                  1'($urandom_range(0, 1)), W'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_chain_sequencer.md
Name: shift_chain_sequencer

Overview:
- Controller that owns and sequences a WIDTH-stage serial-in/parallel-out D-flip-flop chain that drives LEDs.
- Two requesters share the chain. A round-robin arbiter grants one requester per transaction.
- The granted word is shifted in MSB-first over WIDTH clocks, held for display, then done is signalled.
- Sits between stimulus sources (switches/test drivers) and the LED-driving register chain.

Parameters:
WIDTH, 4, number of chain stages / data word width (>=2)
HOLD_CYCLES, 2, cycles the completed word is held before next accept (>=1)

Ports:
input_clock  in  1  single clock; all state updates on posedge
input_reset  in  1  synchronous, active-high reset
input_req0_valid  in  1  requester 0 has a word
input_req0_data  in  WIDTH  requester 0 word
output_req0_ready  out  1  requester 0 word accepted this cycle
input_req1_valid  in  1  requester 1 has a word
input_req1_data  in  WIDTH  requester 1 word
output_req1_ready  out  1  requester 1 word accepted this cycle
output_busy  out  1  high in SHIFT and HOLD
output_grant_id  out  1  requester owning current/last transaction
output_shift_en  out  1  chain shifts this cycle
output_serial_bit  out  1  bit entering stage 0 this cycle
output_leds  out  WIDTH  chain stage outputs, [0] = first stage
output_done  out  1  one-cycle completion pulse
output_parity  out  1  see Optional Feature

Behaviour:
- Reset (synchronous, sampled at posedge): state=IDLE, output_leds=0, tx word=0, counter=0, output_grant_id=0, last-grant pointer=1 (req0 wins first tie), output_done=0, output_parity=0. All readies, busy and shift_en are 0 while input_reset is high.
- States: IDLE, SHIFT, HOLD.
- IDLE:
  - Readies are combinational: ready_n = (state==IDLE) & grant_n & !input_reset.
  - Grant with a single valid: that requester.
  - Grant with both valid: the requester other than the last-grant pointer.
  - On accept (valid&ready): latch data into tx, set grant_id and pointer to the winner, counter=0, go to SHIFT.
  - No valid: stay in IDLE; chain holds.
- SHIFT:
  - shift_en=1; serial_bit = tx[WIDTH-1-counter].
  - Each edge: leds[0]<=serial_bit, leds[i]<=leds[i-1].
  - After WIDTH cycles output_leds equals the accepted word; go to HOLD with counter=0.
- HOLD:
  - shift_en=0; chain holds.
  - Stays HOLD_CYCLES cycles; output_done=1 during the last HOLD cycle only; then go to IDLE.
- Timing: accept at edge T; shift cycles T+1..T+WIDTH; done in cycle T+WIDTH+HOLD_CYCLES. A new accept is possible in cycle T+WIDTH+HOLD_CYCLES+1. Occupancy is WIDTH+HOLD_CYCLES+1 cycles.
- Valid asserted while busy: ignored, ready=0, no data loss inside the block (the requester must hold valid).
- Valid deasserted before accept: no effect.
- Reset during SHIFT/HOLD: the transaction is aborted, chain cleared, no done pulse.
- Counter width is $clog2(max(WIDTH,HOLD_CYCLES)+1) and wraps only via explicit reload.
- output_leds reflects partial contents during SHIFT; this is intentional and visible.

Optional Feature:
- Macro SHIFT_CHAIN_SEQ_PARITY_EN.
- Defined: output_parity is registered at accept with the even parity (XOR) of the accepted word, and is held until the next accept or reset.
- Undefined: output_parity is tied 0 and no parity logic is synthesized. The port is always present.

Decomposition:
- Shared package shift_chain_pkg:
  - state enum (IDLE, SHIFT, HOLD)
  - requester-id typedef
  - default WIDTH/HOLD_CYCLES constants
- One natural sub-module: rr_arbiter2 (2-way round-robin, pointer input/update, combinational grant).
- The chain and FSM stay in the top.

Test Plan (WIDTH=4, HOLD_CYCLES=2):
- Reset, then req0 valid data=4'b1011 -> ready0 pulses 1 cycle; serial_bit 1,0,1,1 over 4 shift cycles; leds=4'b1011 after 4th shift; done pulses 2 cycles later; leds hold 4'b1011.
- req0=4'b0001 and req1=4'b1000 both held valid -> req0 granted first, then req1 at next IDLE; grant_id 0 then 1; leds 4'b0001 then 4'b1000.
- req1 valid during SHIFT of a req0 transaction -> ready1 stays 0 until IDLE; accepted exactly 7 cycles after the req0 accept.
- Reset asserted at 2nd SHIFT cycle -> next cycle leds=0, state IDLE, busy=0, no done pulse.
- Back-to-back req0 only, data 4'b1111 then 4'b0000 -> second accept in the cycle right after done; leds end at 4'b0000.
- With SHIFT_CHAIN_SEQ_PARITY_EN: accept 4'b0111 -> parity=1; accept 4'b0110 -> parity=0. Without the macro, parity stays 0.
